// File: rtl/nram_fill_pkg.sv
// Shared types for the nibble-writable RAM with background fill engine.
// Holds the fill FSM encoding and the supported read-latency range.
package nram_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic bit read_lat_legal(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/nram_lane.sv
// One 4-bit single-port RAM plane, read-before-write, registered read port.
// Latency: read data valid one cycle after rd_en; write lands on the same edge.
// Backpressure: none; every access completes in the cycle it is presented.
module nram_lane #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              rd_en,
    input  logic [3:0]        din,
    output logic [3:0]        dout
);

    logic [3:0] mem [0:(1<<ADDR_W)-1];

    // Storage is deliberately not reset so a reset mid-fill leaves partial contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Non-blocking semantics return the pre-write word on a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/nram_fill.sv
// Nibble-writable RAM with a background fill engine that yields to host access.
// Latency: host read data READ_LAT cycles after rd_en; fill writes one word per free cycle.
// Backpressure: any host read or write stalls the fill; the stalled address is retried.
module nram_fill
    import nram_fill_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NIBBLES  = 6,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [NIBBLES-1:0]   we,
    input  logic                 rd_en,
    input  logic [4*NIBBLES-1:0] data_in,
    output logic [4*NIBBLES-1:0] data_out,
    output logic                 rd_valid,
    input  logic                 fill_start,
    input  logic                 fill_abort,
    input  logic [ADDR_W-1:0]    fill_base,
    input  logic [ADDR_W:0]      fill_len,
    input  logic [4*NIBBLES-1:0] fill_value,
    input  logic [NIBBLES-1:0]   fill_mask,
    output logic                 fill_busy,
    output logic                 fill_done
);

    localparam int W = 4 * NIBBLES;
    // An unsupported latency falls back to the single-cycle read path.
    localparam int LAT = read_lat_legal(READ_LAT) ? READ_LAT : READ_LAT_MIN;

    fill_state_t        state;
    logic [ADDR_W-1:0]  f_addr;
    logic [ADDR_W:0]    f_rem;
    logic [W-1:0]       f_value;
    logic [NIBBLES-1:0] f_mask;

    logic               host_acc;
    logic               fill_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [W-1:0]       mem_din;
    logic [NIBBLES-1:0] mem_we;
    logic [W-1:0]       lane_q;

    assign host_acc = rd_en | (|we);
    assign fill_wr  = (state == RUN) && !host_acc;
    assign mem_addr = host_acc ? addr : f_addr;
    assign mem_din  = host_acc ? data_in : f_value;
    assign mem_we   = host_acc ? we : (fill_wr ? f_mask : '0);

    for (genvar g = 0; g < NIBBLES; g++) begin : g_lane
        nram_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .addr    (mem_addr),
            .we      (mem_we[g]),
            .rd_en   (rd_en),
            .din     (mem_din[4*g +: 4]),
            .dout    (lane_q[4*g +: 4])
        );
    end

    if (LAT == 2) begin : g_lat2
        logic         rd_v1;
        logic         rd_v2;
        logic [W-1:0] dout_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_v1  <= 1'b0;
                rd_v2  <= 1'b0;
                dout_q <= '0;
            end else begin
                rd_v1 <= rd_en;
                rd_v2 <= rd_v1;
                if (rd_v1) begin
                    dout_q <= lane_q;
                end
            end
        end

        assign rd_valid = rd_v2;
        assign data_out = dout_q;
    end else begin : g_lat1
        logic rd_v1;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_v1 <= 1'b0;
            end else begin
                rd_v1 <= rd_en;
            end
        end

        // Lane registers only load on rd_en, so data_out already holds between reads.
        assign rd_valid = rd_v1;
        assign data_out = lane_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            f_addr    <= '0;
            f_rem     <= '0;
            f_value   <= '0;
            f_mask    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        f_addr  <= fill_base;
                        f_rem   <= fill_len;
                        f_value <= fill_value;
                        f_mask  <= fill_mask;
                        if (fill_len == '0) begin
                            state     <= DONE;
                            fill_done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            fill_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The write in the abort cycle still lands; only the FSM stops.
                    if (fill_abort) begin
                        state     <= IDLE;
                        fill_busy <= 1'b0;
                    end else if (fill_wr) begin
                        f_addr <= f_addr + 1'b1;
                        f_rem  <= f_rem - 1'b1;
                        if (f_rem == (ADDR_W+1)'(1)) begin
                            state     <= DONE;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    fill_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nram_fill.sv
// Directed bench for nram_fill: host reads scored through an expectation queue,
// fill timing and contents checked against values computed here.
module tb_nram_fill;

    localparam int ADDR_W   = 14;
    localparam int NIBBLES  = 6;
    localparam int READ_LAT = 1;
    localparam int W        = 4 * NIBBLES;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] addr;
    logic [NIBBLES-1:0] we;
    logic              rd_en;
    logic [W-1:0]      data_in;
    logic [W-1:0]      data_out;
    logic              rd_valid;
    logic              fill_start;
    logic              fill_abort;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_len;
    logic [W-1:0]      fill_value;
    logic [NIBBLES-1:0] fill_mask;
    logic              fill_busy;
    logic              fill_done;

    nram_fill #(.ADDR_W(ADDR_W), .NIBBLES(NIBBLES), .READ_LAT(READ_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (addr),
        .we         (we),
        .rd_en      (rd_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_mask  (fill_mask),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] dat;
        int           due;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read scoreboard: data and exact arrival cycle of every host read.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.tag, "_data"}, 32'(data_out), 32'(e.dat));
                    chk({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_missing"}, 32'(rd_valid), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [W-1:0] d,
                              input logic [NIBBLES-1:0] w);
        addr    = a;
        data_in = d;
        we      = w;
        step();
        we      = '0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic [W-1:0] exp,
                             input string tag);
        addr  = a;
        rd_en = 1'b1;
        sb.push_back('{dat: exp, due: cyc + READ_LAT, tag: tag});
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Iteration 0 pulses fill_start; post-edge samples count busy/done cycles.
    task automatic run_fill(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                            input logic [W-1:0] val, input logic [NIBBLES-1:0] mask,
                            input logic [63:0] rd_sched, input int abort_at,
                            input int start2_at, output int busy_cnt, output int done_cnt,
                            output int first_busy, output int done_at);
        busy_cnt   = 0;
        done_cnt   = 0;
        first_busy = 0;
        done_at    = -1;
        for (int i = 0; i < 64; i++) begin
            fill_start = (i == 0) || (i == start2_at);
            if (i == 0) begin
                fill_base  = base;
                fill_len   = len;
                fill_value = val;
                fill_mask  = mask;
            end else begin
                fill_base  = 14'h0600;
                fill_len   = 15'd5;
                fill_value = 24'hDEAD00;
                fill_mask  = 6'h3F;
            end
            fill_abort = (i == abort_at);
            rd_en      = rd_sched[i];
            addr       = 14'h0010;
            if (rd_sched[i]) sb.push_back('{dat: 24'h222222, due: cyc + READ_LAT, tag: "rd_stall"});
            step();
            fill_start = 1'b0;
            fill_abort = 1'b0;
            rd_en      = 1'b0;
            if (i == 0) first_busy = int'(fill_busy);
            if (fill_busy) busy_cnt++;
            if (fill_done) begin
                done_cnt++;
                done_at = i;
            end
        end
        drain();
    endtask

    int busy_cnt, done_cnt, first_busy, done_at;

    initial begin
        reset_n    = 1'b0;
        addr       = '0;
        we         = '0;
        rd_en      = 1'b0;
        data_in    = '0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_value = '0;
        fill_mask  = '0;

        repeat (3) step();
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_fill_busy", 32'(fill_busy), 32'd0);
        chk("reset_fill_done", 32'(fill_done), 32'd0);
        reset_n = 1'b1;
        step();

        // Full-word write then read back.
        host_write(14'h0010, 24'hABCDEF, 6'h3F);
        host_read(14'h0010, 24'hABCDEF, "rd_full");
        drain();

        // Partial nibble write: lanes 0 and 2 only.
        host_write(14'h0010, 24'h111111, 6'h05);
        host_read(14'h0010, 24'hABC1E1, "rd_nibble");
        drain();
        step();
        step();
        chk("data_out_hold", 32'(data_out), 32'hABC1E1);
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);

        // Same-cycle read and write returns the old word.
        addr    = 14'h0010;
        data_in = 24'h222222;
        we      = 6'h3F;
        rd_en   = 1'b1;
        sb.push_back('{dat: 24'hABC1E1, due: cyc + READ_LAT, tag: "rd_rbw"});
        step();
        we      = '0;
        rd_en   = 1'b0;
        host_read(14'h0010, 24'h222222, "rd_after_rbw");
        drain();

        // Fill wrapping past the top of memory.
        host_write(14'h0002, 24'h123456, 6'h3F);
        host_write(14'h3FFD, 24'h654321, 6'h3F);
        run_fill(14'h3FFE, 15'd4, 24'h777777, 6'h3F, 64'd0, -1, -1,
                 busy_cnt, done_cnt, first_busy, done_at);
        chk("wrap_busy_first", 32'(first_busy), 32'd1);
        chk("wrap_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("wrap_done_pulses", 32'(done_cnt), 32'd1);
        chk("wrap_done_at", 32'(done_at), 32'd4);
        host_read(14'h3FFE, 24'h777777, "wrap_3ffe");
        host_read(14'h3FFF, 24'h777777, "wrap_3fff");
        host_read(14'h0000, 24'h777777, "wrap_0000");
        host_read(14'h0001, 24'h777777, "wrap_0001");
        host_read(14'h0002, 24'h123456, "wrap_0002_untouched");
        host_read(14'h3FFD, 24'h654321, "wrap_3ffd_untouched");
        drain();

        // Fill with a partial lane mask (lanes 0 and 3).
        host_write(14'h0200, 24'h000000, 6'h3F);
        host_write(14'h0201, 24'h000000, 6'h3F);
        run_fill(14'h0200, 15'd2, 24'hFFFFFF, 6'h09, 64'd0, -1, -1,
                 busy_cnt, done_cnt, first_busy, done_at);
        chk("mask_done_pulses", 32'(done_cnt), 32'd1);
        host_read(14'h0200, 24'h00F00F, "mask_0200");
        host_read(14'h0201, 24'h00F00F, "mask_0201");
        drain();

        // Host reads stall an 8-word fill; a second fill_start while busy is ignored.
        host_write(14'h0600, 24'hABABAB, 6'h3F);
        host_write(14'h0408, 24'h999999, 6'h3F);
        run_fill(14'h0400, 15'd8, 24'h3C3C3C, 6'h3F, 64'h34, -1, 6,
                 busy_cnt, done_cnt, first_busy, done_at);
        chk("stall_busy_cycles", 32'(busy_cnt), 32'd11);
        chk("stall_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++) host_read(14'h0400 + 14'(i), 24'h3C3C3C, "stall_word");
        host_read(14'h0408, 24'h999999, "stall_no_overrun");
        host_read(14'h0600, 24'hABABAB, "busy_start_ignored");
        drain();

        // Abort on the third RUN cycle of a 10-word fill.
        for (int i = 0; i < 4; i++) host_write(14'h0100 + 14'(i), 24'h5A5A5A, 6'h3F);
        run_fill(14'h0100, 15'd10, 24'hC0FFEE, 6'h3F, 64'd0, 3, -1,
                 busy_cnt, done_cnt, first_busy, done_at);
        chk("abort_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        host_read(14'h0100, 24'hC0FFEE, "abort_0100");
        host_read(14'h0101, 24'hC0FFEE, "abort_0101");
        host_read(14'h0102, 24'hC0FFEE, "abort_0102");
        host_read(14'h0103, 24'h5A5A5A, "abort_0103_untouched");
        drain();

        // fill_start and fill_abort together in IDLE: the start wins.
        run_fill(14'h0700, 15'd2, 24'h0F0F0F, 6'h3F, 64'd0, 0, -1,
                 busy_cnt, done_cnt, first_busy, done_at);
        chk("start_wins_busy", 32'(busy_cnt), 32'd2);
        chk("start_wins_done", 32'(done_cnt), 32'd1);
        host_read(14'h0701, 24'h0F0F0F, "start_wins_0701");
        drain();

        // Zero-length fill.
        host_write(14'h0800, 24'hA5A5A5, 6'h3F);
        run_fill(14'h0800, 15'd0, 24'h000000, 6'h3F, 64'd0, -1, -1,
                 busy_cnt, done_cnt, first_busy, done_at);
        chk("len0_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("len0_done_pulses", 32'(done_cnt), 32'd1);
        chk("len0_done_at", 32'(done_at), 32'd0);
        host_read(14'h0800, 24'hA5A5A5, "len0_unchanged");
        drain();

        // Reset asserted mid-fill after two words are written.
        host_write(14'h0902, 24'h246802, 6'h3F);
        fill_base  = 14'h0900;
        fill_len   = 15'd20;
        fill_value = 24'h135791;
        fill_mask  = 6'h3F;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        step();
        step();
        chk("busy_before_reset", 32'(fill_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_async_busy", 32'(fill_busy), 32'd0);
        chk("reset_async_done", 32'(fill_done), 32'd0);
        chk("reset_async_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_async_data_out", 32'(data_out), 32'd0);
        reset_n = 1'b1;
        step();
        step();
        chk("busy_after_reset", 32'(fill_busy), 32'd0);
        host_read(14'h0900, 24'h135791, "partial_0900");
        host_read(14'h0901, 24'h135791, "partial_0901");
        host_read(14'h0902, 24'h246802, "partial_0902_untouched");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
